// File: rtl/disp_source_sel.sv
// Debug-value selector for the 4-digit 7-seg driver: two debounced buttons step through
// eight 16-bit pages of CPU state, and a freeze switch holds the displayed number.
module disp_source_sel #(
  parameter int DEB_CYCLES = 1_000_000,
  parameter int CNT_W      = 20
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        btn_next,
  input  logic        btn_prev,
  input  logic        freeze,
  input  logic [31:0] pc,
  input  logic [31:0] instr,
  input  logic [31:0] alu_out,
  input  logic [31:0] rf_rdata,
  input  logic [3:0]  cpu_state,
  output logic [2:0]  page,
  output logic [15:0] number
);

  localparam logic [CNT_W-1:0] DEB_MAX = CNT_W'(DEB_CYCLES - 1);
  localparam int BTN_NEXT = 0;
  localparam int BTN_PREV = 1;

  logic [1:0]            w_btn_raw;
  logic [1:0]            r_sync1;
  logic [1:0]            r_sync2;
  logic [1:0]            r_stable;
  logic [1:0]            r_stable_q;
  logic [1:0][CNT_W-1:0] r_cnt;
  logic [1:0]            w_stable_nxt;
  logic [1:0][CNT_W-1:0] w_cnt_nxt;
  logic [1:0]            w_pulse;
  logic [2:0]            r_page;
  logic [2:0]            w_page_nxt;
  logic [15:0]           r_number;
  logic [15:0]           w_sel;

  assign w_btn_raw = {btn_prev, btn_next};

  // Two-flop synchroniser per button; nothing downstream looks at the raw pins.
  // NOTE: sequential state uses non-blocking (<=) so every flop samples pre-edge values.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_sync1 <= '0;
      r_sync2 <= '0;
    end else begin
      r_sync1 <= w_btn_raw;
      r_sync2 <= r_sync1;
    end
  end

  // NOTE: every always_comb output gets a default first, so no path can infer a latch.
  always_comb begin
    w_stable_nxt = r_stable;
    w_cnt_nxt    = r_cnt;
    for (int i = 0; i < 2; i++) begin
      if (r_sync2[i] != r_stable[i]) begin
        if (r_cnt[i] == DEB_MAX) begin
          w_stable_nxt[i] = r_sync2[i];
          w_cnt_nxt[i]    = '0;
        end else begin
          w_cnt_nxt[i] = r_cnt[i] + 1'b1;
        end
      end else begin
        // Any bounce back to the accepted level restarts the stability window.
        w_cnt_nxt[i] = '0;
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_stable   <= '0;
      r_stable_q <= '0;
      r_cnt      <= '0;
    end else begin
      r_stable   <= w_stable_nxt;
      r_stable_q <= r_stable;
      r_cnt      <= w_cnt_nxt;
    end
  end

  // Press edge only; releases never step the page.
  assign w_pulse = r_stable & ~r_stable_q;

  always_comb begin
    w_page_nxt = r_page;
    case (w_pulse)
      2'b01:   w_page_nxt = r_page + 3'd1;
      2'b10:   w_page_nxt = r_page - 3'd1;
      default: w_page_nxt = r_page;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_page <= '0;
    end else begin
      r_page <= w_page_nxt;
    end
  end

  always_comb begin
    w_sel = '0;
    case (r_page)
      3'd0:    w_sel = pc[15:0];
      3'd1:    w_sel = pc[31:16];
      3'd2:    w_sel = instr[15:0];
      3'd3:    w_sel = instr[31:16];
      3'd4:    w_sel = alu_out[15:0];
      3'd5:    w_sel = alu_out[31:16];
      3'd6:    w_sel = rf_rdata[15:0];
      default: w_sel = {cpu_state, 9'b0, r_page};
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_number <= '0;
    end else if (!freeze) begin
      r_number <= w_sel;
    end
  end

  // Sanity checks on the debounce counter sizing, kept out of synthesis by construction.
  if (DEB_CYCLES < 1) begin : g_bad_deb
    $error("DEB_CYCLES must be at least 1");
  end
  if ((DEB_CYCLES - 1) >= (2 ** CNT_W)) begin : g_bad_cnt_w
    $error("CNT_W too narrow for DEB_CYCLES-1");
  end

  assign page   = r_page;
  assign number = r_number;

endmodule
